mult_div_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers. Sits directly downstream of the register file.
- Consumes the two register-file read ports (RD1 → SrcA, RD2 → SrcB) for MULT/MULTU/DIV/DIVU.
- Serves MTHI/MTLO writes and MFHI/MFLO reads.
- Exposes Busy so the control unit stalls the datapath until results are ready.

---
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mult_div_unit.sv | 144 ++++++++++++++
 tb/tb_mult_div_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Operand, control and HI/LO result bundle between the datapath and mult_div_unit.
// The master drives operands and controls; the slave returns HI/LO, Busy and Done.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Start;
    logic [1:0]       Op;
    logic             HiWE;
    logic             LoWE;
    logic [WIDTH-1:0] HiLoWD;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Busy;
    logic             Done;

    modport master (
        output SrcA, SrcB, Start, Op, HiWE, LoWE, HiLoWD,
        input  Hi, Lo, Busy, Done
    );

    modport slave (
        input  SrcA, SrcB, Start, Op, HiWE, LoWE, HiLoWD,
        output Hi, Lo, Busy, Done
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Define MDU_SIGNED_EN to make Op[1] select signed MULT/DIV; otherwise Op[1] is ignored.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic             CLK,
    input logic             reset,
    mult_div_unit_if.slave  mdu
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     opnd_reg;
    logic [WIDTH-1:0]     a_raw_reg;
    logic                 div_reg;
    logic                 b_zero_reg;
    logic [WIDTH-1:0]     hi_reg, lo_reg;
    logic                 done_reg;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_step;
    logic [WIDTH-1:0]     fin_hi, fin_lo;

`ifdef MDU_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_q_reg, neg_r_reg;

    assign a_neg = mdu.Op[1] & mdu.SrcA[WIDTH-1];
    assign b_neg = mdu.Op[1] & mdu.SrcB[WIDTH-1];
    assign a_mag = a_neg ? -mdu.SrcA : mdu.SrcA;
    assign b_mag = b_neg ? -mdu.SrcB : mdu.SrcB;
`else
    logic unused_op1;

    assign unused_op1 = mdu.Op[1];
    assign a_mag      = mdu.SrcA;
    assign b_mag      = mdu.SrcB;
`endif

    // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits}; quotient bits enter at the bottom.
    assign div_diff = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_reg};
    assign div_step = div_diff[WIDTH] ? {acc_reg[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mdu.Start) state_next = mdu.Op[0] ? DIV : MUL;
            MUL:     if (cnt_reg == LAST) state_next = FIN;
            DIV:     if (cnt_reg == LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fin_hi = acc_reg[2*WIDTH-1:WIDTH];
        fin_lo = acc_reg[WIDTH-1:0];
`ifdef MDU_SIGNED_EN
        if (!div_reg && neg_q_reg) begin
            {fin_hi, fin_lo} = -acc_reg;
        end
        if (div_reg && neg_q_reg) fin_lo = -acc_reg[WIDTH-1:0];
        if (div_reg && neg_r_reg) fin_hi = -acc_reg[2*WIDTH-1:WIDTH];
`endif
        // Divide by zero reports the original dividend, never a sign-adjusted one.
        if (div_reg && b_zero_reg) begin
            fin_lo = '1;
            fin_hi = a_raw_reg;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            a_raw_reg  <= '0;
            div_reg    <= 1'b0;
            b_zero_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
`ifdef MDU_SIGNED_EN
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mdu.Start) begin
                        cnt_reg    <= '0;
                        div_reg    <= mdu.Op[0];
                        a_raw_reg  <= mdu.SrcA;
                        b_zero_reg <= (mdu.SrcB == '0);
                        opnd_reg   <= mdu.Op[0] ? b_mag : a_mag;
                        acc_reg    <= {{WIDTH{1'b0}}, (mdu.Op[0] ? a_mag : b_mag)};
`ifdef MDU_SIGNED_EN
                        neg_q_reg  <= a_neg ^ b_neg;
                        neg_r_reg  <= a_neg;
`endif
                    end else begin
                        if (mdu.HiWE) hi_reg <= mdu.HiLoWD;
                        if (mdu.LoWE) lo_reg <= mdu.HiLoWD;
                    end
                end
                MUL: begin
                    acc_reg <= mul_step;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                DIV: begin
                    acc_reg <= div_step;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                FIN: begin
                    hi_reg   <= fin_hi;
                    lo_reg   <= fin_lo;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mdu.Hi   = hi_reg;
    assign mdu.Lo   = lo_reg;
    assign mdu.Busy = (state_reg != IDLE);
    assign mdu.Done = done_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: reset, MTHI/MTLO, multiply/divide results, latency and handshake.
// Expected values for Op[1]=1 follow MDU_SIGNED_EN when the bench is built with the same define.
module tb_mult_div_unit;
    logic CLK = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    mult_div_unit_if #(.WIDTH(32)) mdu ();

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK   (CLK),
        .reset (reset),
        .mdu   (mdu)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an operation for one cycle (the Start-sampling edge), then scramble the operands.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic with_write);
        @(negedge CLK);
        mdu.Start  = 1'b1;
        mdu.Op     = op;
        mdu.SrcA   = a;
        mdu.SrcB   = b;
        mdu.HiWE   = with_write;
        mdu.LoWE   = with_write;
        mdu.HiLoWD = 32'hDEAD_BEEF;
        @(negedge CLK);
        mdu.Start  = 1'b0;
        mdu.HiWE   = 1'b0;
        mdu.LoWE   = 1'b0;
        mdu.SrcA   = 32'h5A5A_5A5A;
        mdu.SrcB   = 32'h3C3C_3C3C;
    endtask

    // Observe 45 cycles after launch; optionally poke Start and MTHI/MTLO while busy.
    task automatic finish_op(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                             input logic inject);
        int busy_n;
        int done_n;
        int done_at;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        for (int i = 0; i < 45; i++) begin
            if (mdu.Busy === 1'b1) busy_n++;
            if (mdu.Done === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            if (inject && i == 5) begin
                mdu.Start  = 1'b1;
                mdu.Op     = 2'b00;
                mdu.HiWE   = 1'b1;
                mdu.LoWE   = 1'b1;
                mdu.HiLoWD = 32'hDEAD_BEEF;
            end
            if (inject && i == 6) begin
                mdu.Start = 1'b0;
                mdu.HiWE  = 1'b0;
                mdu.LoWE  = 1'b0;
            end
            @(negedge CLK);
        end
        check({tag, " busy_cycles"}, 64'(busy_n), 64'd33);
        check({tag, " done_pulses"}, 64'(done_n), 64'd1);
        check({tag, " done_latency"}, 64'(done_at), 64'd33);
        check({tag, " hi"}, 64'(mdu.Hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(mdu.Lo), 64'(exp_lo));
        $display("op %s: hi=%h lo=%h busy=%0d done=%0d at=%0d", tag, mdu.Hi, mdu.Lo,
                 busy_n, done_n, done_at);
    endtask

    initial begin
        reset      = 1'b1;
        mdu.SrcA   = '0;
        mdu.SrcB   = '0;
        mdu.Start  = 1'b0;
        mdu.Op     = 2'b00;
        mdu.HiWE   = 1'b0;
        mdu.LoWE   = 1'b0;
        mdu.HiLoWD = '0;
        repeat (2) @(negedge CLK);
        check("reset hi", 64'(mdu.Hi), 64'h0);
        check("reset lo", 64'(mdu.Lo), 64'h0);
        check("reset busy", 64'(mdu.Busy), 64'h0);
        check("reset done", 64'(mdu.Done), 64'h0);
        $display("reset: hi=%h lo=%h busy=%b done=%b", mdu.Hi, mdu.Lo, mdu.Busy, mdu.Done);
        reset = 1'b0;

        // MTHI+MTLO together, then MTHI alone
        mdu.HiWE = 1'b1; mdu.LoWE = 1'b1; mdu.HiLoWD = 32'hDEAD_BEEF;
        @(negedge CLK);
        mdu.HiWE = 1'b0; mdu.LoWE = 1'b0;
        check("mthilo hi", 64'(mdu.Hi), 64'hDEAD_BEEF);
        check("mthilo lo", 64'(mdu.Lo), 64'hDEAD_BEEF);
        $display("mthi+mtlo: hi=%h lo=%h", mdu.Hi, mdu.Lo);
        mdu.HiWE = 1'b1; mdu.HiLoWD = 32'h1111_1111;
        @(negedge CLK);
        mdu.HiWE = 1'b0;
        check("mthi hi", 64'(mdu.Hi), 64'h1111_1111);
        check("mthi lo", 64'(mdu.Lo), 64'hDEAD_BEEF);
        $display("mthi: hi=%h lo=%h", mdu.Hi, mdu.Lo);

        // Reset ten cycles into a multiply
        launch(2'b00, 32'hFFFF_FFFF, 32'h2, 1'b0);
        repeat (9) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        check("midreset hi", 64'(mdu.Hi), 64'h0);
        check("midreset lo", 64'(mdu.Lo), 64'h0);
        check("midreset busy", 64'(mdu.Busy), 64'h0);
        check("midreset done", 64'(mdu.Done), 64'h0);
        $display("mid-op reset: hi=%h lo=%h busy=%b done=%b", mdu.Hi, mdu.Lo, mdu.Busy, mdu.Done);

        launch(2'b00, 32'hFFFF_FFFF, 32'h2, 1'b0);
        finish_op("multu_ffffffff_x2", 32'h1, 32'hFFFF_FFFE, 1'b0);

        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        finish_op("multu_max_x_max", 32'hFFFF_FFFE, 32'h1, 1'b0);

        // Start and MTHI/MTLO while busy must both be ignored
        launch(2'b01, 32'd100, 32'd7, 1'b0);
        finish_op("divu_100_7_busy_poke", 32'd2, 32'd14, 1'b1);

        launch(2'b01, 32'hFFFF_FFFF, 32'h10, 1'b0);
        finish_op("divu_max_16", 32'hF, 32'h0FFF_FFFF, 1'b0);

        launch(2'b01, 32'h1234, 32'h0, 1'b0);
        finish_op("divu_by_zero", 32'h1234, 32'hFFFF_FFFF, 1'b0);

        // Start together with MTHI/MTLO: the write is dropped
        launch(2'b00, 32'd3, 32'd5, 1'b1);
        check("start_wins hi_after_e0", 64'(mdu.Hi), 64'h1234);
        check("start_wins lo_after_e0", 64'(mdu.Lo), 64'hFFFF_FFFF);
        finish_op("multu_3x5_with_write", 32'h0, 32'd15, 1'b0);

`ifdef MDU_SIGNED_EN
        launch(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0);
        finish_op("mult_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        launch(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        finish_op("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        finish_op("div_min_m1", 32'h0, 32'h8000_0000, 1'b0);
`else
        launch(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0);
        finish_op("mult_m3x5_unsigned", 32'h4, 32'hFFFF_FFF1, 1'b0);
        launch(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        finish_op("div_m7_2_unsigned", 32'h1, 32'h7FFF_FFFC, 1'b0);
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        finish_op("div_min_m1_unsigned", 32'h8000_0000, 32'h0, 1'b0);
`endif
        launch(2'b11, 32'hFFFF_FFFB, 32'h0, 1'b0);
        finish_op("div_m5_by_zero", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
